// File: rtl/jpeg_pkg.sv
// Shared JPEG constants and the byte-streamer state encoding.
package jpeg_pkg;

  localparam logic [7:0] JPEG_MARK_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_MARK_EOI    = 8'hD9;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    PAD,
    DONE
  } stream_state_t;

endpackage

// File: rtl/byte_fifo2.sv
// Two-entry synchronous byte FIFO; flush wins over push/pop.
module byte_fifo2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [1:0] count,
  output logic [7:0] head
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/jpeg_byte_streamer.sv
// Streams a JPEG image from byte memory to the decoder, stopping at EOI or
// length, then pads with 0x00 until the pixel sink finishes or the budget ends.
module jpeg_byte_streamer
  import jpeg_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int PAD_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [PAD_W-1:0]  pad_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              ready,
  input  logic              pix_done,
  output logic              eoi_seen,
  output logic              busy,
  output logic              done
);

  stream_state_t state, state_nx;

  logic [ADDR_W:0]  rd_addr, xfer_cnt, len_q, xfer_nx;
  logic [PAD_W-1:0] pad_len_q, pad_cnt;
  logic             rd_pend, prev_ff, eoi_q;

  logic [1:0] fifo_count, occ;
  logic [7:0] fifo_head, stream_byte;
  logic       fifo_empty, fifo_push, fifo_pop;
  logic       start_ok, stream_valid, pad_valid, s_xfer;
  logic       eoi_hit, len_hit, stream_exit;

  byte_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (stream_exit),
    .din   (mem_rdata),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // With the FIFO empty the returning read byte is presented directly; if it is
  // not taken it is pushed, so the head holds it stable on the following cycles.
  always_comb begin
    fifo_empty   = (fifo_count == 2'd0);
    occ          = fifo_count + {1'b0, rd_pend};
    start_ok     = start && ((state == IDLE) || (state == DONE));
    stream_valid = (state == STREAM) && (!fifo_empty || rd_pend);
    stream_byte  = fifo_empty ? mem_rdata : fifo_head;
    pad_valid    = (state == PAD) && (pad_cnt != pad_len_q);
    s_xfer       = stream_valid && ready;
    xfer_nx      = xfer_cnt + 1'b1;
    eoi_hit      = s_xfer && prev_ff && (stream_byte == JPEG_MARK_EOI);
    len_hit      = s_xfer && (xfer_nx == len_q);
    stream_exit  = eoi_hit || len_hit;
    fifo_pop     = s_xfer && !fifo_empty;
    fifo_push    = rd_pend && !(fifo_empty && s_xfer);

    mem_rd     = (state == STREAM) && (rd_addr < len_q) && (occ < 2'd2);
    mem_addr   = mem_rd ? rd_addr[ADDR_W-1:0] : '0;
    byte_valid = stream_valid || pad_valid;
    byte_out   = stream_valid ? stream_byte : 8'h00;
    eoi_seen   = eoi_q;
    busy       = (state == STREAM) || (state == PAD);
    done       = (state == DONE);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start)       state_nx = (len == '0) ? PAD : STREAM;
      STREAM:     if (stream_exit) state_nx = PAD;
      PAD:        if (pix_done || (pad_cnt == pad_len_q)) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      xfer_cnt  <= '0;
      len_q     <= '0;
      pad_len_q <= '0;
      pad_cnt   <= '0;
      rd_pend   <= 1'b0;
      prev_ff   <= 1'b0;
      eoi_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        len_q     <= len;
        pad_len_q <= pad_len;
        rd_addr   <= '0;
        xfer_cnt  <= '0;
        pad_cnt   <= '0;
        rd_pend   <= 1'b0;
        prev_ff   <= 1'b0;
        eoi_q     <= 1'b0;
      end else begin
        rd_pend <= mem_rd && !stream_exit;
        if (mem_rd) rd_addr <= rd_addr + 1'b1;
        if (s_xfer) begin
          xfer_cnt <= xfer_nx;
          prev_ff  <= (stream_byte == JPEG_MARK_PREFIX);
        end
        if (eoi_hit) eoi_q <= 1'b1;
        if (pad_valid && ready && (pad_cnt != '1)) pad_cnt <= pad_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_byte_streamer.sv
// Directed self-checking bench for jpeg_byte_streamer.
module tb_jpeg_byte_streamer;

  localparam int ADDR_W = 19;
  localparam int PAD_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n, start, ready, pix_done;
  logic [ADDR_W:0]   len;
  logic [PAD_W-1:0]  pad_len;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic [7:0]        byte_out;
  logic              byte_valid, eoi_seen, busy, done;

  jpeg_byte_streamer #(.ADDR_W(ADDR_W), .PAD_W(PAD_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .pad_len    (pad_len),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .ready      (ready),
    .pix_done   (pix_done),
    .eoi_seen   (eoi_seen),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:63];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[5:0]];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rx  [$];
  int         rxc [$];
  logic [7:0] exp [$];

  bit         mon_en = 1'b0;
  bit         tog    = 1'b0;
  int         viol, issued, len_tb, max_addr;
  logic       p_valid = 1'b0, p_ready = 1'b0;
  logic [7:0] p_byte  = 8'h00;

  always @(negedge clk) begin
    if (mon_en) begin
      if (p_valid && !p_ready && !(byte_valid && byte_out == p_byte)) viol++;
      if (mem_rd) begin
        issued++;
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        if (issued - ((rx.size() < len_tb) ? rx.size() : len_tb) > 2) viol++;
      end
    end
    p_valid = byte_valid;
    p_ready = ready;
    p_byte  = byte_out;
    if (rst_n && byte_valid && ready) begin
      rx.push_back(byte_out);
      rxc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, "_count"}, rx.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < rx.size()) ? {24'h0, rx[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
  endtask

  task automatic load(input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem[i] = v[63-8*i -: 8];
  endtask

  task automatic do_start(input int l, input int p);
    rx.delete();
    rxc.delete();
    @(posedge clk); #1;
    len     = l[ADDR_W:0];
    pad_len = p[PAD_W-1:0];
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      if (done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      if (tog) ready = (k % 3 == 2);
    end
    chk("wait_done", {31'h0, ok}, 32'd1);
    ready = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_rd"}, {31'h0, mem_rd}, 32'd0);
    chk({tag, "_mem_addr"}, {13'h0, mem_addr}, 32'd0);
    chk({tag, "_byte_out"}, {24'h0, byte_out}, 32'd0);
    chk({tag, "_byte_valid"}, {31'h0, byte_valid}, 32'd0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
    chk({tag, "_done"}, {31'h0, done}, 32'd0);
    chk({tag, "_eoi"}, {31'h0, eoi_seen}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b1; pix_done = 1'b0;
    len = '0; pad_len = '0;
    load(64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    // 1: plain stream, ready high, checks first-byte latency
    load(64'h11223344_00000000);
    do_start(4, 3);
    chk("t1_rd_T1", {31'h0, mem_rd}, 32'd1);
    chk("t1_addr_T1", {13'h0, mem_addr}, 32'd0);
    chk("t1_valid_T1", {31'h0, byte_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_T2", {31'h0, byte_valid}, 32'd1);
    chk("t1_byte_T2", {24'h0, byte_out}, 32'h11);
    wait_done(100);
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
    chk_rx("t1");
    chk("t1_consec", (rxc.size() >= 4) ? rxc[3] - rxc[0] : -1, 32'd3);
    chk("t1_done", {31'h0, done}, 32'd1);
    chk("t1_eoi", {31'h0, eoi_seen}, 32'd0);

    // 2: ready toggling; byte stability and read throttling
    viol = 0; issued = 0; len_tb = 4; max_addr = 0;
    mon_en = 1'b1; tog = 1'b1;
    do_start(4, 3);
    wait_done(200);
    mon_en = 1'b0; tog = 1'b0;
    chk_rx("t2");
    chk("t2_viol", viol, 32'd0);
    chk("t2_issued", issued, 32'd4);
    chk("t2_max_addr", max_addr, 32'd3);

    // 3: EOI in the middle of the file
    load(64'hFFD8AAFFD9BBCC00);
    do_start(7, 2);
    wait_done(100);
    exp = '{8'hFF, 8'hD8, 8'hAA, 8'hFF, 8'hD9, 8'h00, 8'h00};
    chk_rx("t3");
    chk("t3_eoi", {31'h0, eoi_seen}, 32'd1);

    // 4a: FF FF D9 is EOI
    load(64'hFFFFD91100000000);
    do_start(4, 1);
    wait_done(100);
    exp = '{8'hFF, 8'hFF, 8'hD9, 8'h00};
    chk_rx("t4a");
    chk("t4a_eoi", {31'h0, eoi_seen}, 32'd1);

    // 4b: FF 00 D9 is not
    load(64'hFF00D9EE00000000);
    do_start(4, 1);
    wait_done(100);
    exp = '{8'hFF, 8'h00, 8'hD9, 8'hEE, 8'h00};
    chk_rx("t4b");
    chk("t4b_eoi", {31'h0, eoi_seen}, 32'd0);

    // 5: pix_done cuts a huge pad budget short
    load(64'h1122000000000000);
    do_start(2, 50000);
    begin
      bit hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk); #1;
        if (rx.size() >= 12) begin hit = 1'b1; break; end
      end
      chk("t5_reach10", {31'h0, hit}, 32'd1);
    end
    pix_done = 1'b1;
    @(negedge clk); #1;
    chk("t5_done", {31'h0, done}, 32'd1);
    chk("t5_valid", {31'h0, byte_valid}, 32'd0);
    chk("t5_padcnt", {31'h0, (rx.size() == 12 || rx.size() == 13)}, 32'd1);
    pix_done = 1'b0;

    // 6: reset during streaming with a read in flight, then a clean restart
    load(64'h1122334455667788);
    do_start(7, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_rd_before_rst", {31'h0, mem_rd}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("t6_rst");
    rst_n = 1'b1;
    load(64'h5AA5000000000000);
    do_start(2, 1);
    wait_done(100);
    exp = '{8'h5A, 8'hA5, 8'h00};
    chk_rx("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jpeg_byte_streamer.md
Name: jpeg_byte_streamer

Overview:
- Hardware source for the decoder's compressed-byte input; it is the transmit end of the byte_in/byte_valid/ready interface.
- Reads a JPEG file from a synchronous byte memory and streams it to jpeg_decoder_top at up to 1 byte/cycle, honouring ready.
- Stops at the EOI marker (FF D9) or at the programmed length, whichever comes first.
- Then emits 0x00 flush bytes to drain the decoder pipeline until the pixel sink reports completion or a pad budget expires.

Parameters:
ADDR_W, 19, memory byte-address width (512 KiB image store)
PAD_W, 16, width of the pad-byte budget counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  pulse: begin streaming; sampled only in IDLE/DONE
len  in  ADDR_W+1  file length in bytes, latched on start
pad_len  in  PAD_W  maximum flush bytes after end of file, latched on start
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  memory byte address
mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd
byte_out  out  8  byte to decoder (byte_in)
byte_valid  out  1  byte_out valid
ready  in  1  decoder can accept a byte
pix_done  in  1  level: pixel sink has received the full frame
eoi_seen  out  1  FF D9 was transferred in this run
busy  out  1  state is not IDLE/DONE
done  out  1  level, held in DONE until the next start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset: state=IDLE; all outputs 0; FIFO empty; counters 0. A reset mid-run aborts immediately, and any in-flight read data is discarded.
- Transfer: one byte moves on each cycle with byte_valid&&ready.
  - In STREAM, once byte_valid is raised, byte_valid and byte_out stay stable until transfer.
- States:
  - IDLE/DONE -> STREAM on start (len>0); clears eoi_seen and the counters.
  - IDLE/DONE -> PAD on start with len==0.
  - start is ignored while busy.
- STREAM prefetch:
  - A 2-entry byte FIFO feeds byte_out from its head.
  - mem_rd=1 when rd_addr<len and (FIFO occupancy + reads in flight)<2.
  - mem_addr=rd_addr; rd_addr increments on each mem_rd.
  - Returned mem_rdata is pushed the following cycle.
  - Sustains 1 byte/cycle with ready held high.
  - Latency: start at cycle T -> mem_rd at T+1 (addr 0) -> byte_valid at T+2.
- EOI detection:
  - Uses the last transferred byte (prev_ff flag) and the current transferred byte.
  - FF followed by D9 sets eoi_seen on the cycle after the D9 transfer and moves the state to PAD.
  - The FIFO is flushed, and any read in flight is dropped.
  - FF FF D9 counts as EOI; FF 00 D9 does not.
- End of length: STREAM -> PAD after the transfer of byte index len-1, even if EOI was never seen.
- PAD:
  - byte_out=0x00 and byte_valid=1; pad_cnt counts transfers.
  - -> DONE when pad_cnt==pad_len, or on the cycle after pix_done is sampled high.
  - pix_done has priority.
  - byte_valid may drop without a transfer in PAD (pad bytes are don't-care).
  - pad_len==0 -> DONE on the next cycle.
- pix_done high during STREAM: no effect; streaming continues.
- DONE: byte_valid=0, mem_rd=0, done=1.
- Widths and counters:
  - rd_addr and the transfer counter are ADDR_W+1 bits; len up to 2^ADDR_W is legal.
  - pad_cnt saturates at all-ones.

Decomposition:
- Shared package jpeg_pkg holds:
  - marker constants JPEG_MARK_PREFIX=8'hFF and JPEG_MARK_EOI=8'hD9;
  - the streamer state enum {IDLE, STREAM, PAD, DONE}.
- One sub-module, byte_fifo2: a 2-entry synchronous FIFO with push, pop, flush, count[1:0], head.
  - The decoder's input buffer can reuse it.

Test Plan:
1. mem = 11 22 33 44, len=4, pad_len=3, ready=1, pix_done=0 -> bytes 11 22 33 44 on 4 consecutive cycles starting T+2, then 00 00 00; done=1; eoi_seen=0.
2. Same image with ready toggling 1,0,0,1,... -> byte_out held during ready=0, order preserved, no mem_rd beyond 2 outstanding or buffered, mem_addr never exceeds 3.
3. mem = FF D8 AA FF D9 BB CC, len=7 -> 5 bytes transferred (BB never sent), eoi_seen=1, then pad bytes.
4. mem = FF FF D9 ... -> EOI after the 3rd byte; mem = FF 00 D9 EE with len=4 -> all 4 bytes sent, eoi_seen=0.
5. pad_len=50000, pix_done asserted after 10 pad transfers -> DONE within 1 cycle, pad count 10 or 11, done=1.
6. rst_n=0 mid-STREAM with a read in flight -> the next cycle has all outputs 0 and IDLE. A new start with len=2 streams bytes 0 and 1 cleanly, with no stale data.
